// File: rtl/baccarat_round_ctrl.sv
// rtl/baccarat_round_ctrl.sv - punto-banco round sequencer (optional auto-step: BACCARAT_AUTO_STEP_EN)
module baccarat_round_ctrl #(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3_val,
    output logic [2:0] load_pcard,
    output logic [2:0] load_dcard,
    output logic       clr_hands,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    typedef enum logic [3:0] {
        S_WAIT_P1 = 4'd0,
        S_WAIT_D1 = 4'd1,
        S_WAIT_P2 = 4'd2,
        S_WAIT_D2 = 4'd3,
        S_DECIDE  = 4'd4,
        S_WAIT_D3 = 4'd5,
        S_SETTLE1 = 4'd6,
        S_SETTLE2 = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    if (STEP_CYCLES < 3) begin : g_step_cycles_check
        $error("STEP_CYCLES must be at least 3");
    end

    state_t     state;
    state_t     state_nxt;
    logic [2:0] lp_nxt;
    logic [2:0] ld_nxt;
    logic       clr_nxt;
    logic       step_src;
    logic       strobe_any;
    logic       accept;
    logic       natural;
    logic       bank_draw;
    logic [3:0] p_eff;
    logic [3:0] d_eff;

`ifdef BACCARAT_AUTO_STEP_EN
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] step_cnt;
    logic             unused_step;

    assign unused_step = step;

    // Free-running divider producing one internal step per STEP_CYCLES clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (step_cnt == CNT_LAST) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    assign step_src = (step_cnt == CNT_LAST);
`else
    assign step_src = step;
`endif

    // A datapath score above 9 is a fault; clamp so the decisions stay sane
    assign p_eff = (pscore > 4'd9) ? 4'd9 : pscore;
    assign d_eff = (dscore > 4'd9) ? 4'd9 : dscore;

    // Holdoff: while a load/clear strobe is in flight the scores are stale
    assign strobe_any = (|load_pcard) | (|load_dcard) | clr_hands;
    assign accept     = step_src & ~strobe_any;
    assign natural    = (p_eff >= 4'd8) || (d_eff >= 4'd8);

    // Banker third-card tableau given the player's third card value
    always_comb begin
        bank_draw = 1'b0;
        case (d_eff)
            4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
            4'd3:    bank_draw = (pcard3_val != 4'd8);
            4'd4:    bank_draw = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
            4'd5:    bank_draw = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
            4'd6:    bank_draw = (pcard3_val == 4'd6) || (pcard3_val == 4'd7);
            default: bank_draw = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT_P1;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: deals advance on accepted steps, settle runs on its own
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_P1: if (accept) state_nxt = S_WAIT_D1;
            S_WAIT_D1: if (accept) state_nxt = S_WAIT_P2;
            S_WAIT_P2: if (accept) state_nxt = S_WAIT_D2;
            S_WAIT_D2: if (accept) state_nxt = S_DECIDE;
            S_DECIDE: begin
                if (accept) begin
                    if (!natural && (p_eff <= 4'd5)) begin
                        state_nxt = S_WAIT_D3;
                    end else begin
                        state_nxt = S_SETTLE1;
                    end
                end
            end
            S_WAIT_D3: if (accept) state_nxt = S_SETTLE1;
            S_SETTLE1: state_nxt = S_SETTLE2;
            S_SETTLE2: state_nxt = S_DONE;
            S_DONE:    if (accept) state_nxt = S_WAIT_P1;
            default:   state_nxt = S_WAIT_P1;
        endcase
    end

    // Strobe selection for the cycle after an accepted step
    always_comb begin
        lp_nxt  = 3'b000;
        ld_nxt  = 3'b000;
        clr_nxt = 1'b0;
        if (accept) begin
            case (state)
                S_WAIT_P1: lp_nxt = 3'b001;
                S_WAIT_D1: ld_nxt = 3'b001;
                S_WAIT_P2: lp_nxt = 3'b010;
                S_WAIT_D2: ld_nxt = 3'b010;
                S_DECIDE: begin
                    if (!natural) begin
                        if (p_eff <= 4'd5) begin
                            lp_nxt = 3'b100;
                        end else if (d_eff <= 4'd5) begin
                            ld_nxt = 3'b100;
                        end
                    end
                end
                S_WAIT_D3: if (bank_draw) ld_nxt = 3'b100;
                S_DONE:    clr_nxt = 1'b1;
                default:   ;
            endcase
        end
    end

    // Registered strobes and result latch; result clears together with clr_hands
    always_ff @(posedge clk) begin
        if (rst) begin
            load_pcard <= 3'b000;
            load_dcard <= 3'b000;
            clr_hands  <= 1'b0;
            done       <= 1'b0;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
        end else begin
            load_pcard <= lp_nxt;
            load_dcard <= ld_nxt;
            clr_hands  <= clr_nxt;
            if (state == S_SETTLE2) begin
                done       <= 1'b1;
                player_win <= (p_eff >= d_eff);
                dealer_win <= (d_eff >= p_eff);
            end else if (clr_nxt) begin
                done       <= 1'b0;
                player_win <= 1'b0;
                dealer_win <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// tb/tb_baccarat_round_ctrl.sv - directed bench for baccarat_round_ctrl with round-level model
module tb_baccarat_round_ctrl;

    // Output vector order: {load_pcard, load_dcard, clr_hands, done, player_win, dealer_win}
    localparam logic [9:0] O_IDLE   = 10'b000_000_0000;
    localparam logic [9:0] O_P1     = 10'b001_000_0000;
    localparam logic [9:0] O_D1     = 10'b000_001_0000;
    localparam logic [9:0] O_P2     = 10'b010_000_0000;
    localparam logic [9:0] O_D2     = 10'b000_010_0000;
    localparam logic [9:0] O_P3     = 10'b100_000_0000;
    localparam logic [9:0] O_D3     = 10'b000_100_0000;
    localparam logic [9:0] O_CLR    = 10'b000_000_1000;
    localparam logic [9:0] O_DONE_P = 10'b000_000_0110;
    localparam logic [9:0] O_DONE_D = 10'b000_000_0101;
    localparam logic [9:0] O_TIE    = 10'b000_000_0111;

    logic       clk;
    logic       rst;
    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3_val;
    logic [2:0] load_pcard;
    logic [2:0] load_dcard;
    logic       clr_hands;
    logic       player_win;
    logic       dealer_win;
    logic       done;

    baccarat_round_ctrl #(.STEP_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .pscore     (pscore),
        .dscore     (dscore),
        .pcard3_val (pcard3_val),
        .load_pcard (load_pcard),
        .load_dcard (load_dcard),
        .clr_hands  (clr_hands),
        .player_win (player_win),
        .dealer_win (dealer_win),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Card datapath stand-in: six card registers loaded from the deck on strobes
    int         dp [3];
    int         dd [3];
    logic [3:0] pc [3];
    logic [3:0] dc [3];
    logic       ovr_en;
    logic [3:0] ovr_p;
    logic [3:0] ovr_d;
    logic [3:0] p_tot;
    logic [3:0] d_tot;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst || clr_hands) begin
                pc[k] <= 4'd0;
                dc[k] <= 4'd0;
            end else begin
                if (load_pcard[k]) pc[k] <= 4'(dp[k]);
                if (load_dcard[k]) dc[k] <= 4'(dd[k]);
            end
        end
    end

    always_comb begin
        p_tot = 4'((int'(pc[0]) + int'(pc[1]) + int'(pc[2])) % 10);
        d_tot = 4'((int'(dc[0]) + int'(dc[1]) + int'(dc[2])) % 10);
    end

    assign pscore     = ovr_en ? ovr_p : p_tot;
    assign dscore     = ovr_en ? ovr_d : d_tot;
    assign pcard3_val = pc[2];

    // Round model: the whole round is planned from the deck as a list of strobes,
    // one consumed per accepted step (code 0 = step accepted with no strobe).
    int plan[$];
    int idx;
    int settle;
    bit m_acc;
    int ps;
    int ds;
    logic [2:0] m_lp;
    logic [2:0] m_ld;
    logic       m_clr;
    logic       m_done;
    logic       m_pw;
    logic       m_dw;

    function automatic int sat(input logic [3:0] v);
        return (v > 4'd9) ? 9 : int'(v);
    endfunction

    function automatic bit banker_draws(input int d, input int p3);
        case (d)
            0, 1, 2: return 1'b1;
            3:       return p3 != 8;
            4:       return (p3 >= 2) && (p3 <= 7);
            5:       return (p3 >= 4) && (p3 <= 7);
            6:       return (p3 == 6) || (p3 == 7);
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_deck(input int p0, input int p1, input int p2,
                            input int d0, input int d1, input int d2);
        int pt;
        int dt;
        dp[0] = p0; dp[1] = p1; dp[2] = p2;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        pt = (p0 + p1) % 10;
        dt = (d0 + d1) % 10;
        plan = {1, 2, 3, 4};
        if (pt >= 8 || dt >= 8) begin
            plan.push_back(0);
        end else if (pt <= 5) begin
            plan.push_back(5);
            plan.push_back(banker_draws(dt, p2) ? 6 : 0);
        end else if (dt <= 5) begin
            plan.push_back(6);
        end else begin
            plan.push_back(0);
        end
    endtask

    always @(posedge clk) begin
        m_acc = step && (m_lp == 3'b000) && (m_ld == 3'b000) && !m_clr;
        m_lp  <= 3'b000;
        m_ld  <= 3'b000;
        m_clr <= 1'b0;
        if (rst) begin
            idx = 0;
            settle = 0;
            m_done <= 1'b0;
            m_pw   <= 1'b0;
            m_dw   <= 1'b0;
        end else if (settle > 0) begin
            settle = settle - 1;
            if (settle == 0) begin
                ps = sat(pscore);
                ds = sat(dscore);
                m_done <= 1'b1;
                m_pw   <= (ps >= ds);
                m_dw   <= (ds >= ps);
            end
        end else if (m_done) begin
            if (m_acc) begin
                m_clr  <= 1'b1;
                m_done <= 1'b0;
                m_pw   <= 1'b0;
                m_dw   <= 1'b0;
                idx = 0;
            end
        end else if (m_acc && idx < plan.size()) begin
            case (plan[idx])
                1:       m_lp <= 3'b001;
                2:       m_ld <= 3'b001;
                3:       m_lp <= 3'b010;
                4:       m_ld <= 3'b010;
                5:       m_lp <= 3'b100;
                6:       m_ld <= 3'b100;
                default: ;
            endcase
            idx = idx + 1;
            if (idx == plan.size()) settle = 2;
        end
    end

    int total;
    int bad;
    bit chk_on;

    function automatic logic [9:0] cur_out();
        return {load_pcard, load_dcard, clr_hands, done, player_win, dealer_win};
    endfunction

    task automatic chk(input string name, input logic [9:0] exp);
        total++;
        if (cur_out() !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, cur_out(), exp);
        end
    endtask

    task automatic do_step(input string name, input logic [9:0] exp);
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        chk(name, exp);
    endtask

    task automatic idle(input string name, input logic [9:0] exp);
        @(posedge clk); #1;
        chk(name, exp);
    endtask

    task automatic deal4(input string tag);
        do_step({tag, "_p1"}, O_P1);
        do_step({tag, "_d1"}, O_D1);
        do_step({tag, "_p2"}, O_P2);
        do_step({tag, "_d2"}, O_D2);
    endtask

    initial begin
        step = 1'b0; rst = 1'b1;
        ovr_en = 1'b0; ovr_p = 4'd0; ovr_d = 4'd0;
        total = 0; bad = 0; chk_on = 1'b0;
        set_deck(3, 5, 0, 1, 2, 0);

        fork
            forever begin
                @(negedge clk);
                if (chk_on) begin
                    total++;
                    if (cur_out() !== {m_lp, m_ld, m_clr, m_done, m_pw, m_dw}) begin
                        bad++;
                        $display("FAIL model_cycle t=%0t: got %b want %b", $time, cur_out(),
                                 {m_lp, m_ld, m_clr, m_done, m_pw, m_dw});
                    end
                end
            end
        join_none

        @(posedge clk); #1 chk_on = 1'b1;
        @(posedge clk); #1;
        chk("reset", O_IDLE);
        rst = 1'b0;

        // Round 1: natural 8 vs 3
        deal4("r1");
        do_step("r1_decide", O_IDLE);
        idle("r1_settle", O_IDLE);
        idle("r1_result", O_DONE_P);

        // Round 2: player 6 stands, banker 4 draws to 9; step in settle ignored
        set_deck(2, 4, 0, 1, 3, 5);
        do_step("r2_clr", O_CLR);
        deal4("r2");
        do_step("r2_decide", O_D3);
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        chk("r2_result", O_DONE_D);
        idle("r2_hold", O_DONE_D);

        // Round 3a: player 2 draws 8, banker 3 stands
        set_deck(1, 1, 8, 1, 2, 0);
        do_step("r3a_clr", O_CLR);
        deal4("r3a");
        do_step("r3a_decide", O_P3);
        do_step("r3a_bank", O_IDLE);
        idle("r3a_settle", O_IDLE);
        idle("r3a_result", O_DONE_D);

        // Round 3b: player draws 7, banker 3 draws 2
        set_deck(1, 1, 7, 1, 2, 2);
        do_step("r3b_clr", O_CLR);
        deal4("r3b");
        do_step("r3b_decide", O_P3);
        do_step("r3b_bank", O_D3);
        idle("r3b_settle", O_IDLE);
        idle("r3b_result", O_DONE_P);

        // Round 4: 5 vs 5 tie, banker 5 stands on a 0
        set_deck(2, 3, 0, 2, 3, 9);
        do_step("r4_clr", O_CLR);
        deal4("r4");
        do_step("r4_decide", O_P3);
        do_step("r4_bank", O_IDLE);
        idle("r4_settle", O_IDLE);
        idle("r4_result", O_TIE);
        set_deck(1, 2, 9, 2, 2, 0);
        do_step("r4_clr_done", O_CLR);

        // Round 5: holdoff on back-to-back steps, then reset in WAIT_D3
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1;
        chk("r5_hold_first", O_P1);
        @(posedge clk); #1 step = 1'b0;
        chk("r5_hold_drop", O_IDLE);
        do_step("r5_d1", O_D1);
        do_step("r5_p2", O_P2);
        do_step("r5_d2", O_D2);
        do_step("r5_decide", O_P3);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("r5_reset_d3", O_IDLE);
        deal4("r5b");
        do_step("r5b_decide", O_P3);
        do_step("r5b_bank", O_IDLE);
        idle("r5b_settle", O_IDLE);
        idle("r5b_result", O_DONE_D);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("r5_reset_done", O_IDLE);

        // Round 6: out-of-range scores clamp to 9, so 12 vs 9 is a tie
        set_deck(4, 4, 0, 0, 0, 0);
        deal4("r6");
        do_step("r6_decide", O_IDLE);
        ovr_p = 4'd12; ovr_d = 4'd9; ovr_en = 1'b1;
        idle("r6_settle", O_IDLE);
        idle("r6_result", O_TIE);
        ovr_en = 1'b0;

        // Round 7: player 7, banker 6, both stand
        set_deck(3, 4, 0, 3, 3, 0);
        do_step("r7_clr", O_CLR);
        deal4("r7");
        do_step("r7_decide", O_IDLE);
        idle("r7_settle", O_IDLE);
        idle("r7_result", O_DONE_P);

        @(posedge clk); #1;
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baccarat_round_ctrl.md
Name: baccarat_round_ctrl

Overview:
- Sequencer for the lab 2 baccarat datapath.
- Deals the four initial cards, one card per accepted step pulse.
- Applies the standard punto-banco third-card rules to the datapath's hand scores, then latches the round winner.
- Sits between the step source (debounced KEY0 pulse) and the card/score datapath, replacing the fixed six-card sequencer.

Parameters:
STEP_CYCLES, 4, auto-step period in clk cycles (only used with BACCARAT_AUTO_STEP_EN); legal range >= 3.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
step  input  1  one-cycle advance pulse
pscore  input  4  player hand score 0-9, combinational from datapath card registers
dscore  input  4  dealer hand score 0-9
pcard3_val  input  4  value 0-9 of player third card (rank >= 10 maps to 0)
load_pcard  output  3  one-hot one-cycle load strobe for player card slot 1/2/3
load_dcard  output  3  one-hot one-cycle load strobe for dealer card slot 1/2/3
clr_hands  output  1  one-cycle clear of all six card registers
player_win  output  1  round result, valid while done
dealer_win  output  1  round result; both wins high = tie
done  output  1  round complete

Behaviour:
- Reset (rst sampled high at posedge): state WAIT_P1; all outputs 0; holdoff cleared. Reset mid-round abandons the round with no strobe. The datapath is reset by the same rst.
- Strobes (load_*, clr_hands) are registered: asserted the cycle after the accepting step, for exactly 1 cycle. At most one strobe bit is high in any cycle.
- Holdoff: a step arriving in a cycle where any strobe is high is ignored (dropped, not queued). This guarantees pscore/dscore reflect the last loaded card at every decision.
- States and transitions on an accepted step:
  - WAIT_P1 -> WAIT_D1, strobe load_pcard=001.
  - WAIT_D1 -> WAIT_P2, strobe load_dcard=001.
  - WAIT_P2 -> WAIT_D2, strobe load_pcard=010.
  - WAIT_D2 -> DECIDE, strobe load_dcard=010.
  - DECIDE, evaluated in the step cycle:
    - pscore >= 8 or dscore >= 8 (natural): -> SETTLE, no strobe.
    - pscore <= 5: -> WAIT_D3, strobe load_pcard=100.
    - pscore 6 or 7 and dscore <= 5: -> SETTLE, strobe load_dcard=100.
    - otherwise: -> SETTLE, no strobe.
  - WAIT_D3, banker rule on dscore and pcard3_val:
    - dscore 0-2: draw.
    - dscore 3: draw unless pcard3_val = 8.
    - dscore 4: draw if pcard3_val 2-7.
    - dscore 5: draw if pcard3_val 4-7.
    - dscore 6: draw if pcard3_val 6-7.
    - dscore 7: stand.
    - Draw -> SETTLE with load_dcard=100; stand -> SETTLE with no strobe.
  - SETTLE: lasts exactly 2 cycles, no step needed; steps during SETTLE are ignored. At the end of the 2nd cycle latch the result and go to DONE:
    - pscore > dscore: player_win=1, dealer_win=0.
    - dscore > pscore: player_win=0, dealer_win=1.
    - equal: both 1.
  - DONE: done=1; results held stable.
  - DONE + accepted step -> WAIT_P1: strobe clr_hands, clear done/player_win/dealer_win in the same cycle as the clr_hands strobe.
- Scores are 4-bit unsigned; values > 9 are a datapath fault and are treated as 9.
- Illegal or unused state encodings -> WAIT_P1 next cycle with no strobe.

Optional Feature:
- Macro: BACCARAT_AUTO_STEP_EN.
- Defined:
  - The step input is ignored.
  - An internal counter of width $clog2(STEP_CYCLES) generates an internal step once every STEP_CYCLES cycles; the counter resets to 0 on rst.
  - Holdoff still applies.
  - DONE also auto-advances, so rounds repeat indefinitely.
- Undefined: only the external step advances the FSM; there is no counter logic.

Test Plan:
1. Natural: steps give P=8, D=3 after the four deals -> next step in DECIDE emits no strobe; 2 cycles later done=1, player_win=1, dealer_win=0.
2. Player stands, banker draws: pscore=6, dscore=4 at DECIDE -> load_dcard=100 for 1 cycle; with final dscore=9, dealer_win=1.
3. Banker 3 rule: pscore=2 -> load_pcard=100. Then pcard3_val=8, dscore=3 -> no strobe, SETTLE. Repeat with pcard3_val=7 -> load_dcard=100.
4. Tie: final pscore=dscore=5 -> done=1, player_win=1, dealer_win=1. Next step -> clr_hands pulse and done=0 in the same cycle.
5. Holdoff: step on two consecutive cycles in WAIT_P1 -> only load_pcard=001 is strobed; the FSM is in WAIT_D1 and the second step is dropped.
6. Reset mid-round: rst high in WAIT_D3 -> next cycle all outputs 0 and state WAIT_P1. With BACCARAT_AUTO_STEP_EN and STEP_CYCLES=4, strobes are spaced exactly 4 cycles apart.
